// File: rtl/mips_dbg_pkg.sv
// Shared types and widths for the post-halt memory dump unit.
package mips_dbg_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BIDX_W         = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } dump_state_t;

    // Zero-extend a byte into the top of a word so it leaves the serializer first.
    function automatic logic [WORD_W-1:0] byte_to_top(input logic [BYTE_W-1:0] b);
        return {b, {(WORD_W-BYTE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads a 32-bit word and emits it MSB-first as bytes on a valid/ready stream.
// load_last_idx selects how many bytes of the word are sent (index of the final byte);
// load_final marks that the final byte of this load is the final byte of the stream.
module word_serializer
    import mips_dbg_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [BIDX_W-1:0] load_last_idx,
    input  logic              load_final,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_last,
    output logic              word_done_c
);

    logic [WORD_W-1:0] sreg;
    logic [BIDX_W-1:0] byte_idx;
    logic [BIDX_W-1:0] last_idx;
    logic              final_q;
    logic              hs_c;

    assign hs_c        = tx_valid && tx_ready;
    assign word_done_c = hs_c && (byte_idx == last_idx);
    assign tx_data     = sreg[WORD_W-1 -: BYTE_W];

    // Shift register, byte index and valid/last hold; a load wins over a handshake.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            sreg     <= '0;
            byte_idx <= '0;
            last_idx <= '0;
            final_q  <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end else if (load) begin
            sreg     <= load_data;
            byte_idx <= '0;
            last_idx <= load_last_idx;
            final_q  <= load_final;
            tx_valid <= 1'b1;
            tx_last  <= load_final && (load_last_idx == '0);
        end else if (hs_c) begin
            sreg <= sreg << BYTE_W;
            if (byte_idx == last_idx) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end else begin
                byte_idx <= BIDX_W'(byte_idx + 1'b1);
                tx_last  <= final_q && (BIDX_W'(byte_idx + 1'b1) == last_idx);
            end
        end
    end

endmodule

// File: rtl/halt_mem_dump.sv
// Post-halt memory dump: on a rising HALTED, reads DUMP_COUNT words starting at
// DUMP_BASE and streams them MSB-first as bytes.
// Optional feature macro DUMP_CHECKSUM_EN appends an XOR checksum byte to the stream.
module halt_mem_dump
    import mips_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DUMP_BASE  = 198,
    parameter int unsigned DUMP_COUNT = 3
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halted,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  COUNT_L = CNT_W'(DUMP_COUNT);
    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(DUMP_BASE);

    dump_state_t       state;
    logic              halted_q;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  wcnt;

    logic              trig_c;
    logic              hs_c;
    logic              last_word_c;
    logic              word_done_c;
    logic              ser_load_c;
    logic [WORD_W-1:0] ser_word_c;
    logic [BIDX_W-1:0] ser_last_idx_c;
    logic              ser_final_c;

`ifdef DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
    logic [BYTE_W-1:0] csum_next_c;

    // Running XOR including the byte being accepted; starts from zero on a trigger.
    assign csum_next_c = (state == IDLE) ? '0 : (csum ^ tx_data);
`endif

    assign trig_c      = (state == IDLE) && halted && !halted_q;
    assign hs_c        = tx_valid && tx_ready;
    assign last_word_c = (CNT_W'(wcnt + 1'b1) == COUNT_L);

    // Serializer load source: a captured memory word, or the checksum byte.
    always_comb begin
        ser_load_c     = 1'b0;
        ser_word_c     = mem_rd_data;
        ser_last_idx_c = BIDX_W'(BYTES_PER_WORD - 1);
        ser_final_c    = 1'b0;
        if (state == CAP) begin
            ser_load_c = 1'b1;
`ifndef DUMP_CHECKSUM_EN
            ser_final_c = last_word_c;
`endif
        end
`ifdef DUMP_CHECKSUM_EN
        else if ((state == SEND && word_done_c && last_word_c) ||
                 (trig_c && (DUMP_COUNT == 0))) begin
            ser_load_c     = 1'b1;
            ser_word_c     = byte_to_top(csum_next_c);
            ser_last_idx_c = '0;
            ser_final_c    = 1'b1;
        end
`endif
    end

    word_serializer u_ser (
        .clk1          (clk1),
        .rst           (rst),
        .load          (ser_load_c),
        .load_data     (ser_word_c),
        .load_last_idx (ser_last_idx_c),
        .load_final    (ser_final_c),
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .word_done_c   (word_done_c)
    );

    // Dump sequencer with address pointer, word counter and registered strobes.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            halted_q    <= 1'b1;
            ptr         <= '0;
            wcnt        <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            halted_q  <= halted;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_c) begin
                        ptr  <= BASE_L;
                        wcnt <= '0;
`ifdef DUMP_CHECKSUM_EN
                        csum <= '0;
`endif
                        if (DUMP_COUNT == 0) begin
`ifdef DUMP_CHECKSUM_EN
                            state <= CSUM;
                            busy  <= 1'b1;
`else
                            state <= DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            state       <= REQ;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= BASE_L;
                            busy        <= 1'b1;
                        end
                    end
                end
                REQ: state <= CAP;
                CAP: state <= SEND;
                SEND: begin
                    if (hs_c) begin
`ifdef DUMP_CHECKSUM_EN
                        csum <= csum_next_c;
`endif
                        if (word_done_c) begin
                            ptr  <= ADDR_W'(ptr + 1'b1);
                            wcnt <= CNT_W'(wcnt + 1'b1);
                            if (last_word_c) begin
`ifdef DUMP_CHECKSUM_EN
                                state <= CSUM;
`else
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                state       <= REQ;
                                mem_rd_en   <= 1'b1;
                                mem_rd_addr <= ADDR_W'(ptr + 1'b1);
                            end
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    if (word_done_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (!halted) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_halt_mem_dump.sv
// Bench for halt_mem_dump: default window, a wrapping window and an empty window.
module tb_halt_mem_dump;

    typedef logic [8:0] bq_t[$];

    typedef struct {
        bit         ready;
        bit         rd_en;
        logic [9:0] addr;
        bit         valid;
        logic [7:0] data;
        bit         last;
        bit         busy;
        bit         done;
    } vec_t;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst, halted, tx_ready;

    logic        rd_en_a, v_a, l_a, busy_a, done_a;
    logic [9:0]  addr_a;
    logic [31:0] rdata_a;
    logic [7:0]  d_a;

    logic        rd_en_b, v_b, l_b, busy_b, done_b;
    logic [9:0]  addr_b;
    logic [31:0] rdata_b;
    logic [7:0]  d_b;

    logic        rd_en_z, v_z, l_z, busy_z, done_z;
    logic [9:0]  addr_z;
    logic [31:0] rdata_z;
    logic [7:0]  d_z;
    assign rdata_z = 32'h0;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];

    always @(posedge clk1) if (rd_en_a) rdata_a <= mem_a[addr_a];
    always @(posedge clk1) if (rd_en_b) rdata_b <= mem_b[addr_b];

    halt_mem_dump u_dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .mem_rd_en(rd_en_a), .mem_rd_addr(addr_a), .mem_rd_data(rdata_a),
        .tx_valid(v_a), .tx_ready(tx_ready), .tx_data(d_a), .tx_last(l_a),
        .busy(busy_a), .done(done_a)
    );

    halt_mem_dump #(.ADDR_W(10), .DUMP_BASE(1023), .DUMP_COUNT(2)) u_wrap (
        .clk1(clk1), .rst(rst), .halted(halted),
        .mem_rd_en(rd_en_b), .mem_rd_addr(addr_b), .mem_rd_data(rdata_b),
        .tx_valid(v_b), .tx_ready(tx_ready), .tx_data(d_b), .tx_last(l_b),
        .busy(busy_b), .done(done_b)
    );

    halt_mem_dump #(.ADDR_W(10), .DUMP_BASE(5), .DUMP_COUNT(0)) u_zero (
        .clk1(clk1), .rst(rst), .halted(halted),
        .mem_rd_en(rd_en_z), .mem_rd_addr(addr_z), .mem_rd_data(rdata_z),
        .tx_valid(v_z), .tx_ready(tx_ready), .tx_data(d_z), .tx_last(l_z),
        .busy(busy_z), .done(done_z)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit ready_pat [0:511];

    bq_t got_a, got_b, got_z;
    logic       stall_a = 1'b0;
    logic [8:0] held_a  = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // Accepted-byte capture and hold-while-stalled checks.
    always @(negedge clk1) begin
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("hold_valid", 32'(v_a), 32'd1);
                chk("hold_byte", 32'({l_a, d_a}), 32'(held_a));
            end
            stall_a = v_a && !tx_ready;
            held_a  = {l_a, d_a};
            if (v_a && tx_ready) got_a.push_back({l_a, d_a});
            if (v_b && tx_ready) got_b.push_back({l_b, d_b});
            if (v_z && tx_ready) got_z.push_back({l_z, d_z});
        end
    end

    // Cycle in which done should first appear, walking the ready pattern byte by byte.
    function automatic int model_done(input int nwords);
        int c = 1;
        for (int w = 0; w < nwords; w++) begin
            c += 2;
            for (int b = 0; b < 4; b++) begin
                while (c < 511 && !ready_pat[c]) c++;
                c++;
            end
        end
`ifdef DUMP_CHECKSUM_EN
        while (c < 511 && !ready_pat[c]) c++;
        c++;
`endif
        return c;
    endfunction

    // Expected {last, byte} stream for up to three words.
    function automatic bq_t expect_stream(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input int n);
        bq_t         q;
        logic [31:0] ws [3];
        logic [7:0]  x;
        logic [7:0]  bt;
        logic        fin;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        x = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                bt = 8'(ws[i] >> (24 - 8 * j));
                x  = x ^ bt;
`ifdef DUMP_CHECKSUM_EN
                fin = 1'b0;
`else
                fin = (i == n - 1) && (j == 3);
`endif
                q.push_back({fin, bt});
            end
        end
`ifdef DUMP_CHECKSUM_EN
        q.push_back({1'b1, x});
`endif
        return q;
    endfunction

    task automatic cmp_stream(input string name, input bq_t got, input bq_t exp);
        chk($sformatf("%s_len", name), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp[i]));
    endtask

    // One dump on all three units; checks streams, done timing, done hold/pulse.
    task automatic run_dump(input string tag, input int drop_at, output int da);
        int  db, dz, wa, wb, ea, eb, ez, lim;
        bit  rdz;
        bq_t xa, xb, xz;
        da = 0; db = 0; dz = 0; wa = 0; wb = 0; rdz = 0;
        xa = expect_stream(mem_a[198], mem_a[199], mem_a[200], 3);
        xb = expect_stream(mem_b[1023], mem_b[0], 32'h0, 2);
        xz = expect_stream(32'h0, 32'h0, 32'h0, 0);
        ea = model_done(3); eb = model_done(2); ez = model_done(0);
        lim = ea + 3;
        got_a.delete(); got_b.delete(); got_z.delete();
        halted = 1'b1;
        for (int k = 1; k <= 450; k++) begin
            @(posedge clk1);
            #1;
            tx_ready = ready_pat[k];
            if (k == drop_at) halted = 1'b0;
            @(negedge clk1);
            if (k == 1) begin
                chk({tag, "_rd_en_c1"}, 32'(rd_en_a), 32'd1);
                chk({tag, "_addr_c1"}, 32'(addr_a), 32'd198);
                chk({tag, "_wrap_addr_c1"}, 32'(addr_b), 32'd1023);
            end
            if (k == 3) chk({tag, "_valid_c3"}, 32'(v_a), 32'd1);
            if (done_a) begin if (da == 0) da = k; wa++; end
            if (done_b) begin if (db == 0) db = k; wb++; end
            if (done_z && dz == 0) dz = k;
            if (rd_en_z) rdz = 1'b1;
            if (k >= lim) break;
        end
        chk({tag, "_done_cyc"}, 32'(da), 32'(ea));
        chk({tag, "_wrap_done_cyc"}, 32'(db), 32'(eb));
        chk({tag, "_zero_done_cyc"}, 32'(dz), 32'(ez));
        chk({tag, "_zero_no_read"}, 32'(rdz), 32'd0);
        cmp_stream({tag, "_a"}, got_a, xa);
        cmp_stream({tag, "_b"}, got_b, xb);
        cmp_stream({tag, "_z"}, got_z, xz);
        if (drop_at == 0) begin
            chk({tag, "_done_held"}, 32'(done_a), 32'd1);
            chk({tag, "_wrap_done_held"}, 32'(done_b), 32'd1);
        end else begin
            chk({tag, "_done_pulse"}, 32'(wa), 32'd1);
            chk({tag, "_wrap_done_pulse"}, 32'(wb), 32'd1);
        end
        halted   = 1'b0;
        tx_ready = 1'b1;
        repeat (3) step();
        chk({tag, "_idle_done"}, 32'({done_a, done_b, done_z}), 32'd0);
        chk({tag, "_idle_busy"}, 32'({busy_a, busy_b, busy_z}), 32'd0);
    endtask

    initial begin
        vec_t        tbl [1:21];
        logic [31:0] fact [3];
        bit          seen;
        int          dcyc;

        fact[0] = 32'd120; fact[1] = 32'd0; fact[2] = 32'd5;
        for (int k = 1; k <= 21; k++) begin
            int w, p;
            tbl[k] = '{ready: 1'b1, rd_en: 1'b0, addr: '0, valid: 1'b0, data: '0,
                       last: 1'b0, busy: 1'b0, done: 1'b0};
            if (k <= 18) begin
                w = (k - 1) / 6;
                p = (k - 1) % 6;
                tbl[k].busy = 1'b1;
                if (p == 0) begin
                    tbl[k].rd_en = 1'b1;
                    tbl[k].addr  = 10'(198 + w);
                end else if (p >= 2) begin
                    tbl[k].valid = 1'b1;
                    tbl[k].data  = 8'(fact[w] >> (8 * (5 - p)));
`ifndef DUMP_CHECKSUM_EN
                    tbl[k].last  = (k == 18);
`endif
                end
            end else begin
`ifdef DUMP_CHECKSUM_EN
                if (k == 19) begin
                    tbl[k].valid = 1'b1;
                    tbl[k].data  = 8'h7D;
                    tbl[k].last  = 1'b1;
                    tbl[k].busy  = 1'b1;
                end else begin
                    tbl[k].done = 1'b1;
                end
`else
                tbl[k].done = 1'b1;
`endif
            end
        end

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        for (int i = 0; i < 512; i++) ready_pat[i] = 1'b1;

        // Reset with the core already halted.
        rst = 1'b1; halted = 1'b1; tx_ready = 1'b1;
        repeat (2) step();
        chk("rst_outputs", 32'({rd_en_a, v_a, l_a, busy_a, done_a}), 32'd0);
        chk("rst_data_addr", 32'({d_a, addr_a}), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (busy_a || v_a || rd_en_a || done_a) seen = 1'b1;
        end
        chk("halted_at_reset_no_dump", 32'(seen), 32'd0);
        halted = 1'b0;
        repeat (2) step();

        // Factorial dump, cycle by cycle.
        mem_a[198] = 32'd120; mem_a[199] = 32'd0; mem_a[200] = 32'd5;
        halted = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk1);
            #1;
            tx_ready = tbl[k].ready;
            @(negedge clk1);
            chk($sformatf("t%0d_rd_en", k), 32'(rd_en_a), 32'(tbl[k].rd_en));
            if (tbl[k].rd_en) chk($sformatf("t%0d_addr", k), 32'(addr_a), 32'(tbl[k].addr));
            chk($sformatf("t%0d_valid", k), 32'(v_a), 32'(tbl[k].valid));
            if (tbl[k].valid) begin
                chk($sformatf("t%0d_data", k), 32'(d_a), 32'(tbl[k].data));
                chk($sformatf("t%0d_last", k), 32'(l_a), 32'(tbl[k].last));
            end
            chk($sformatf("t%0d_busy", k), 32'(busy_a), 32'(tbl[k].busy));
            chk($sformatf("t%0d_done", k), 32'(done_a), 32'(tbl[k].done));
        end
        halted = 1'b0;
        repeat (3) step();

        // Wrap window with the reference words.
        mem_b[1023] = 32'hDEADBEEF; mem_b[0] = 32'h280A00C8;
        run_dump("wrap", 0, dcyc);
        chk("wrap_first_byte", 32'(got_b.size() > 0 ? got_b[0][7:0] : 8'hxx), 32'hDE);
        chk("wrap_fifth_byte", 32'(got_b.size() > 4 ? got_b[4][7:0] : 8'hxx), 32'h28);

        // Back-pressure: ready low for five cycles while byte 2 is offered.
        for (int k = 4; k <= 8; k++) ready_pat[k] = 1'b0;
        run_dump("bp", 0, dcyc);
`ifdef DUMP_CHECKSUM_EN
        chk("bp_done_late", 32'(dcyc), 32'd25);
`else
        chk("bp_done_late", 32'(dcyc), 32'd24);
`endif
        for (int k = 0; k < 512; k++) ready_pat[k] = 1'b1;

        // halted drops mid-dump: dump completes, done pulses once.
        run_dump("drop", 5, dcyc);

        // Reset after the 6th byte.
        got_a.delete();
        halted = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (got_a.size() >= 6) break;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(v_a), 32'd0);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (busy_a || v_a || rd_en_a || done_a) seen = 1'b1;
        end
        chk("rst_mid_no_restart", 32'(seen), 32'd0);
        chk("rst_mid_bytes", 32'(got_a.size()), 32'd6);
        halted = 1'b0;
        repeat (2) step();
        run_dump("after_rst", 0, dcyc);

        // Randomized contents and ready patterns.
        for (int r = 0; r < 6; r++) begin
            for (int i = 198; i <= 200; i++) mem_a[i] = $urandom;
            mem_b[1023] = $urandom;
            mem_b[0]    = $urandom;
            for (int k = 0; k < 450; k++) ready_pat[k] = ($urandom_range(0, 3) != 0);
            run_dump($sformatf("rnd%0d", r), (r % 2 == 1) ? $urandom_range(2, 15) : 0, dcyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
